// File: rtl/fifo_pkg.sv
// Shared asynchronous-FIFO definitions: default pointer geometry and Gray/binary helpers
// used by both the write-side and read-side pointer controllers.
package fifo_pkg;

  localparam int ADDR_WIDTH = 3;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
  localparam int FUNC_WIDTH = 16;

  function automatic logic [FUNC_WIDTH-1:0] bin2gray(input logic [FUNC_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Callers zero-extend narrower pointers; leading zeros do not disturb the prefix XOR.
  function automatic logic [FUNC_WIDTH-1:0] gray2bin(input logic [FUNC_WIDTH-1:0] gray);
    logic [FUNC_WIDTH-1:0] bin_v;
    bin_v = gray;
    for (int i = 1; i < FUNC_WIDTH; i++) begin
      bin_v = bin_v ^ (gray >> i);
    end
    return bin_v;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module fifo_gray2bin #(
  parameter int Width = 4
) (
  input  logic [Width-1:0] gray,
  output logic [Width-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = gray;
    for (int i = Width - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag controller of the asynchronous FIFO: drives the memory write
// port, exports the Gray write pointer and derives full/almost-full/level/overflow in Wclk.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int Data_width         = 8,
  parameter int Depth              = 8,
  parameter int Address_width      = ADDR_WIDTH,
  parameter int Almost_full_margin = 2
) (
  input  logic                     Wclk,
  input  logic                     Wrst,
  input  logic                     Winc,
  input  logic [Address_width:0]   Wq2_rptr,
  output logic                     Wclken,
  output logic [Address_width-1:0] Wadder,
  output logic [Address_width:0]   Wptr,
  output logic                     Wfull,
  output logic                     Walmost_full,
  output logic [Address_width:0]   Wlevel,
  output logic                     Woverflow
);

  localparam int PW = Address_width + 1;
  localparam logic [PW-1:0] DEPTH_P   = PW'(Depth);
  localparam logic [PW-1:0] AF_THRESH = PW'(Depth - Almost_full_margin);

  if ((Data_width < 1) || (Address_width < 2) || (Depth != (1 << Address_width)) ||
      (Almost_full_margin < 1) || (Almost_full_margin > Depth - 1)) begin : g_bad_params
    $error("fifo_wptr_full: illegal parameter combination");
  end

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] wgray_next_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_cmp_s;
  logic [PW-1:0] diff_s;
  logic [PW-1:0] level_next_s;
  logic          full_next_s;
  logic          af_next_s;

  fifo_gray2bin #(.Width(PW)) u_rptr_g2b (
    .gray (Wq2_rptr),
    .bin  (rbin_s)
  );

  // A write presented during reset never reaches the memory.
  assign Wclken = Winc & ~Wfull & ~Wrst;
  assign Wadder = wbin_r[Address_width-1:0];

  // Next-state pointers and flags, evaluated on the post-write pointer and current read pointer.
  always_comb begin
    wbin_next_s  = wbin_r + {{(PW-1){1'b0}}, Wclken};
    wgray_next_s = PW'(bin2gray(FUNC_WIDTH'(wbin_next_s)));
    full_cmp_s   = {~Wq2_rptr[PW-1:PW-2], Wq2_rptr[PW-3:0]};
    full_next_s  = (wgray_next_s == full_cmp_s);
    diff_s       = wbin_next_s - rbin_s;
    af_next_s    = (diff_s >= AF_THRESH);
    if (diff_s > DEPTH_P) begin
      level_next_s = DEPTH_P;
    end else begin
      level_next_s = diff_s;
    end
  end

  // Pointer and flag registers; overflow stays set until reset.
  always_ff @(posedge Wclk) begin
    if (Wrst) begin
      wbin_r       <= '0;
      Wptr         <= '0;
      Wfull        <= 1'b0;
      Walmost_full <= 1'b0;
      Wlevel       <= '0;
      Woverflow    <= 1'b0;
    end else begin
      wbin_r       <= wbin_next_s;
      Wptr         <= wgray_next_s;
      Wfull        <= full_next_s;
      Walmost_full <= af_next_s;
      Wlevel       <= level_next_s;
      Woverflow    <= Woverflow | (Winc & Wfull);
    end
  end

endmodule
